// File: rtl/data_mem_if.sv
// data_mem_if: load/store request and response bundle between the core's
// control unit (master) and the data-memory responder (slave).
//   req_valid/req_ready  request handshake
//   req_we               1 = store, 0 = load
//   req_funct3           RV32 size/sign code
//   req_addr             byte address
//   req_wdata            right-aligned store data
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            extended load result (0 for stores and errors)
//   rsp_err              misaligned, out-of-range or illegal funct3
interface data_mem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory end of the load/store path. Accepts one request
// at a time, waits LATENCY cycles, performs the RAM access with RV32 size and
// sign rules, and holds the response until the consumer takes it.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (RAM contents are kept)
//   bus  data_mem_if slave port (request and response handshakes)
// Parameters: ADDR_W word-address width (2**ADDR_W x 32b RAM),
//             LATENCY wait cycles between accept and response (0..15).
module data_mem_responder #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic       clk,
   input  logic       rst,
   data_mem_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic        we_reg;
   logic [2:0]  f3_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;

   logic        accept;
   logic        access;
   logic        misaligned, out_of_range, illegal, err;
   logic [3:0]  be;
   logic [31:0] lane_data;
   logic [31:0] ram_q;
   logic [31:0] shifted;
   logic [31:0] load_data;
   logic [ADDR_W-1:0] word_idx;

   logic [31:0] mem [0:(2**ADDR_W)-1];

   // req_ready drops with rst so nothing can be accepted while reset is held.
   assign bus.req_ready = (state_reg == IDLE) && !rst;
   assign accept        = bus.req_valid && bus.req_ready;
   assign access        = (state_reg == WAIT) && (cnt_reg == 4'd0);
   assign word_idx      = addr_reg[ADDR_W+1:2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = WAIT;
               cnt_next   = 4'(LATENCY);
            end
         end
         WAIT: begin
            if (cnt_reg == 4'd0) state_next = RESP;
            else                 cnt_next   = cnt_reg - 4'd1;
         end
         RESP: begin
            if (bus.rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The captured request is the only source used after accept, so later
   // changes on the request inputs cannot leak into the access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_reg    <= 1'b0;
         f3_reg    <= 3'b000;
         addr_reg  <= 32'd0;
         wdata_reg <= 32'd0;
      end else if (accept) begin
         we_reg    <= bus.req_we;
         f3_reg    <= bus.req_funct3;
         addr_reg  <= bus.req_addr;
         wdata_reg <= bus.req_wdata;
      end
   end

   assign misaligned   = ((f3_reg[1:0] == 2'b01) && addr_reg[0]) ||
                         ((f3_reg[1:0] == 2'b10) && (addr_reg[1:0] != 2'b00));
   assign out_of_range = |addr_reg[31:ADDR_W+2];
   // 011 and 111 share f3[1:0]==11; unsigned codes are load-only.
   assign illegal      = (f3_reg[1:0] == 2'b11) || (f3_reg == 3'b110) ||
                         (we_reg && f3_reg[2]);
   assign err          = misaligned || out_of_range || illegal;

   // Byte enables and lane-replicated store data: a byte store copies
   // wdata[7:0] to every lane, a half store copies wdata[15:0] to both halves.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign be[gi] = (f3_reg[1:0] == 2'b00) ? (addr_reg[1:0] == 2'(gi)) :
                         (f3_reg[1:0] == 2'b01) ? (addr_reg[1] == 1'(gi / 2)) :
                                                  1'b1;
         assign lane_data[8*gi +: 8] =
                         (f3_reg[1:0] == 2'b00) ? wdata_reg[7:0] :
                         (f3_reg[1:0] == 2'b01) ? wdata_reg[8*(gi % 2) +: 8] :
                                                  wdata_reg[8*gi +: 8];
      end
   endgenerate

   // Registered-read RAM with byte-lane writes; the read word is captured on
   // the access edge and stays put for the whole RESP phase.
   always_ff @(posedge clk) begin
      if (access && !rst) begin
         if (we_reg && !err) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
         end
         ram_q <= mem[word_idx];
      end
   end

   assign shifted = ram_q >> {addr_reg[1:0], 3'b000};

   always_comb begin
      load_data = shifted;
      case (f3_reg)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_data = {24'd0, shifted[7:0]};
         3'b101:  load_data = {16'd0, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   assign bus.rsp_valid = (state_reg == RESP);
   assign bus.rsp_err   = (state_reg == RESP) && err;
   assign bus.rsp_rdata = ((state_reg == RESP) && !err && !we_reg) ? load_data : 32'd0;
endmodule
